// File: rtl/alu_writeback.sv
// Execute/writeback stage behind the ALU: registers results, owns the C/S/O/Z flag
// register, resolves conditional branches and squashes younger beats after a redirect.
//   state    | meaning
//   S_RUN    | accepting beats whenever stall is low
//   S_HALTED | HLT retired; in_ready held low until reset
module alu_writeback #(
    parameter int BITS_DATA   = 32,
    parameter int BITS_ADDR   = 16,
    parameter int BITS_REG    = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 stall,
    input  logic [4:0]           in_opcode,
    input  logic [BITS_REG-1:0]  in_rd,
    input  logic [BITS_DATA-1:0] in_resultado,
    input  logic                 in_C,
    input  logic                 in_S,
    input  logic                 in_O,
    input  logic                 in_Z,
    input  logic [BITS_ADDR-1:0] in_target,
    output logic                 wb_en,
    output logic [BITS_REG-1:0]  wb_addr,
    output logic [BITS_DATA-1:0] wb_data,
    output logic                 flag_C,
    output logic                 flag_S,
    output logic                 flag_O,
    output logic                 flag_Z,
    output logic                 branch_taken,
    output logic [BITS_ADDR-1:0] branch_target,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_BITS-1:0]  retired
);

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_LD  = 5'd1;
    localparam logic [4:0] OP_STR = 5'd2;
    localparam logic [4:0] OP_NOT = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_NEG = 5'd7;
    localparam logic [4:0] OP_ADD = 5'd8;
    localparam logic [4:0] OP_SUB = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;
    localparam logic [4:0] OP_DIV = 5'd11;
    localparam logic [4:0] OP_MOD = 5'd12;
    localparam logic [4:0] OP_JMP = 5'd13;
    localparam logic [4:0] OP_JC  = 5'd14;
    localparam logic [4:0] OP_JS  = 5'd15;
    localparam logic [4:0] OP_JO  = 5'd16;
    localparam logic [4:0] OP_JZ  = 5'd17;
    localparam logic [4:0] OP_HLT = 5'd18;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t                state_q, state_d;
    logic [2:0]            flush_q, flush_d;
    logic [3:0]            flags_q, flags_d;
    logic                  wb_en_q, wb_en_d;
    logic [BITS_REG-1:0]   wb_addr_q, wb_addr_d;
    logic [BITS_DATA-1:0]  wb_data_q, wb_data_d;
    logic                  br_q, br_d;
    logic [BITS_ADDR-1:0]  target_q, target_d;
    logic                  illegal_q, illegal_d;
    logic [CNT_BITS-1:0]   retired_q, retired_d;

    logic accept, live, is_alu, is_branch, is_hlt, is_other, br_cond;

    always_comb begin
        is_alu    = 1'b0;
        is_branch = 1'b0;
        is_hlt    = 1'b0;
        is_other  = 1'b0;
        br_cond   = 1'b0;
        case (in_opcode)
            OP_NOT, OP_AND, OP_OR, OP_NEG, OP_ADD, OP_SUB: is_alu = 1'b1;
            OP_NOP, OP_LD, OP_STR, OP_XOR, OP_MUL, OP_DIV, OP_MOD: is_other = 1'b1;
            OP_JMP: begin is_branch = 1'b1; br_cond = 1'b1;       end
            OP_JC:  begin is_branch = 1'b1; br_cond = flags_q[3]; end
            OP_JS:  begin is_branch = 1'b1; br_cond = flags_q[2]; end
            OP_JO:  begin is_branch = 1'b1; br_cond = flags_q[1]; end
            OP_JZ:  begin is_branch = 1'b1; br_cond = flags_q[0]; end
            OP_HLT: is_hlt = 1'b1;
            default: ;
        endcase
    end

    assign accept = in_valid & in_ready;
    // Beats accepted while the flush counter is non-zero are younger than a taken branch.
    assign live   = accept & (flush_q == 3'd0);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && live && is_hlt) state_d = S_HALTED;
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_RUN) & ~stall;
        halted   = (state_q == S_HALTED);
    end

    always_comb begin
        flush_d   = flush_q;
        flags_d   = flags_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        br_d      = 1'b0;
        target_d  = target_q;
        illegal_d = 1'b0;
        retired_d = retired_q;
        if (accept && flush_q != 3'd0) begin
            flush_d = flush_q - 3'd1;
        end else if (live) begin
            if (retired_q != {CNT_BITS{1'b1}}) retired_d = retired_q + 1'b1;
            if (is_alu) begin
                wb_en_d   = 1'b1;
                wb_addr_d = in_rd;
                wb_data_d = in_resultado;
                flags_d   = {in_C, in_S, in_O, in_Z};
            end
            if (is_branch && br_cond) begin
                br_d     = 1'b1;
                target_d = in_target;
                flush_d  = FLUSH_INIT;
            end
            if (!is_alu && !is_branch && !is_hlt && !is_other) illegal_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q   <= '0;
            flags_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            br_q      <= 1'b0;
            target_q  <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            flush_q   <= flush_d;
            flags_q   <= flags_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            br_q      <= br_d;
            target_q  <= target_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign wb_en         = wb_en_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data       = wb_data_q;
    assign {flag_C, flag_S, flag_O, flag_Z} = flags_q;
    assign branch_taken  = br_q;
    assign branch_target = target_q;
    assign illegal       = illegal_q;
    assign retired       = retired_q;

endmodule
